// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock / reset sequencer.
package pll_seq_pkg;

  // Width of the per-state cycle counter.
  localparam int CNT_W  = 24;
  // Width of the saturating event counters.
  localparam int STAT_W = 8;

  typedef enum logic [1:0] {
    ST_RESET_PLL = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } seq_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous status bit.
// Output q follows d two clk edges later; both flops clear in reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Capture the async input, then re-register it to let metastability settle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_reset_seq.sv
// PLL lock / reset sequencer.
// Pulses the PLL reset, waits for lock, requires lock to stay high for a
// stable window, then releases the downstream reset. Lock loss in RUN or a
// lock-wait timeout restarts the sequence. All outputs are registered and
// decoded from the next state so they move in the same cycle as the state.
// dbg_state exposes the current state for observation.
module pll_lock_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_PULSE     = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned STABLE_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_lock,
  output logic              pll_reset,
  output logic              sys_rst_n,
  output logic              ready,
  output logic [STAT_W-1:0] loss_count,
  output logic [STAT_W-1:0] timeout_count,
  output seq_state_e        dbg_state
);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic              lock_s;

  seq_state_e        state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [STAT_W-1:0] loss_q,      loss_d;
  logic [STAT_W-1:0] timeout_q,   timeout_d;
  logic              pll_reset_q, pll_reset_d;
  logic              sys_rst_n_q, sys_rst_n_d;
  logic              ready_q,     ready_d;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // Next-state, counter and output decode; lock wins over timeout in WAIT_LOCK.
  always_comb begin
    state_d   = state_q;
    loss_d    = loss_q;
    timeout_d = timeout_q;

    case (state_q)
      ST_RESET_PLL: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == LOCK_LAST) begin
          state_d   = ST_RESET_PLL;
          timeout_d = sat_inc(timeout_q);
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          loss_d  = sat_inc(loss_q);
        end
      end
      default: state_d = ST_RESET_PLL;
    endcase

    // Counter restarts on every state entry; it has no job in RUN, so it holds.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == ST_RUN) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    pll_reset_d = (state_d == ST_RESET_PLL);
    sys_rst_n_d = (state_d == ST_RUN);
    ready_d     = (state_d == ST_RUN);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RESET_PLL;
      cnt_q       <= '0;
      loss_q      <= '0;
      timeout_q   <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      loss_q      <= loss_d;
      timeout_q   <= timeout_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
    end
  end

  assign pll_reset     = pll_reset_q;
  assign sys_rst_n     = sys_rst_n_q;
  assign ready         = ready_q;
  assign loss_count    = loss_q;
  assign timeout_count = timeout_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Bench for pll_lock_reset_seq with RST_PULSE=4, LOCK_TIMEOUT=20,
// STABLE_CYCLES=8. Inputs are driven and outputs sampled 1 time unit after
// each rising clk edge. Latencies are counted in clk edges from the
// observation point at which an input change is driven: a pll_lock change
// needs 2 edges through the synchronizer and 1 more to register the state.
module tb_pll_lock_reset_seq;
  import pll_seq_pkg::*;

  localparam int RST_PULSE     = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int BUDGET        = 200;

  localparam int SEL_PLL_RESET = 0;
  localparam int SEL_SYS_RST_N = 1;
  localparam int SEL_READY     = 2;

  // {pll_reset, sys_rst_n, ready, loss_count, timeout_count}
  localparam logic [31:0] RESET_PACK = {13'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pll_lock;
  logic        pll_reset;
  logic        sys_rst_n;
  logic        ready;
  logic [7:0]  loss_count;
  logic [7:0]  timeout_count;
  seq_state_e  dbg_state;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] exp_q[$];
  logic        sys_seen;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time limit reached, tests_run=%0d", tests_run);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  pll_lock_reset_seq #(
    .RST_PULSE     (RST_PULSE),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pll_lock      (pll_lock),
    .pll_reset     (pll_reset),
    .sys_rst_n     (sys_rst_n),
    .ready         (ready),
    .loss_count    (loss_count),
    .timeout_count (timeout_count),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic sb_check(input string tag, input logic [31:0] got);
    logic [31:0] exp;
    if (exp_q.size() == 0) begin
      $display("scoreboard empty at %s", tag);
      exp = 32'hFFFF_FFFF;
    end else begin
      exp = exp_q.pop_front();
    end
    check_eq(tag, got, exp);
  endtask

  function automatic logic [31:0] pack_out();
    return {13'd0, pll_reset, sys_rst_n, ready, loss_count, timeout_count};
  endfunction

  function automatic logic pick(input int sel);
    case (sel)
      SEL_PLL_RESET: return pll_reset;
      SEL_SYS_RST_N: return sys_rst_n;
      default:       return ready;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    sys_seen = sys_seen | sys_rst_n;
  endtask

  // Step until the selected output equals v; n carries on from its input value.
  task automatic wait_cond(input int sel, input logic v, inout int n);
    while (pick(sel) !== v && n < BUDGET) begin
      step();
      n++;
    end
  endtask

  // Hold rst_n low for ncyc edges, check reset values, then release.
  task automatic apply_reset(input int ncyc);
    rst_n = 1'b0;
    repeat (ncyc) step();
    expect_val(RESET_PACK);
    sb_check("reset_outputs", pack_out());
    expect_val(ST_RESET_PLL);
    sb_check("reset_state", dbg_state);
    rst_n    = 1'b1;
    sys_seen = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    sys_seen = 1'b0;

    // Startup: pulse length, then lock 10 cycles after release.
    apply_reset(3);
    n = 0;
    expect_val(RST_PULSE);
    wait_cond(SEL_PLL_RESET, 1'b0, n);
    sb_check("startup_pulse_len", n);
    repeat (10 - RST_PULSE) step();
    pll_lock = 1'b1;
    n = 0;
    expect_val(2 + 1 + STABLE_CYCLES);
    wait_cond(SEL_READY, 1'b1, n);
    sb_check("lock_to_ready", n);
    expect_val(1);
    sb_check("sys_rst_n_with_ready", sys_rst_n);
    expect_val(0);
    sb_check("pll_reset_in_run", pll_reset);

    // Lock toggling during the reset pulse changes nothing.
    pll_lock = 1'b0;
    apply_reset(2);
    pll_lock = 1'b1;
    step();
    pll_lock = 1'b0;
    n = 1;
    expect_val(RST_PULSE);
    wait_cond(SEL_PLL_RESET, 1'b0, n);
    sb_check("pulse_len_lock_toggle", n);
    repeat (3) step();
    expect_val(ST_WAIT_LOCK);
    sb_check("ignore_lock_in_reset", dbg_state);

    // No lock: periodic re-pulse and saturating timeout count.
    apply_reset(2);
    n = 0;
    expect_val(RST_PULSE);
    wait_cond(SEL_PLL_RESET, 1'b0, n);
    sb_check("nolock_first_pulse", n);
    for (int k = 1; k <= 258; k++) begin
      n = 0;
      wait_cond(SEL_PLL_RESET, 1'b1, n);
      if (k <= 3) begin
        expect_val(LOCK_TIMEOUT);
        sb_check("nolock_wait_len", n);
      end
      if (k == 3 || k == 254 || k == 255 || k == 258) begin
        expect_val((k > 255) ? 255 : k);
        sb_check("timeout_count", timeout_count);
      end
      n = 0;
      wait_cond(SEL_PLL_RESET, 1'b0, n);
      if (k <= 3) begin
        expect_val(RST_PULSE);
        sb_check("nolock_repulse_len", n);
      end
    end
    expect_val(0);
    sb_check("nolock_sys_never_high", sys_seen);

    // Lock loss from RUN: 1-cycle drop.
    apply_reset(2);
    pll_lock = 1'b1;
    n = 0;
    expect_val(RST_PULSE + 1 + STABLE_CYCLES);
    wait_cond(SEL_READY, 1'b1, n);
    sb_check("release_to_run_lock_high", n);
    pll_lock = 1'b0;
    step();
    pll_lock = 1'b1;
    n = 1;
    expect_val(3);
    wait_cond(SEL_SYS_RST_N, 1'b0, n);
    sb_check("drop_to_sys_rst_fall", n);
    expect_val(1);
    sb_check("loss_count", loss_count);
    expect_val(0);
    sb_check("ready_after_loss", ready);
    expect_val(ST_WAIT_LOCK);
    sb_check("state_after_loss", dbg_state);
    n = 0;
    expect_val(1 + STABLE_CYCLES);
    wait_cond(SEL_READY, 1'b1, n);
    sb_check("loss_to_rerun", n);

    // Glitch in STABLE: lock_s low while STABLE cnt==6 (pin dropped at cnt 4).
    pll_lock = 1'b0;
    apply_reset(2);
    n = 0;
    wait_cond(SEL_PLL_RESET, 1'b0, n);
    pll_lock = 1'b1;
    repeat (7) step();
    expect_val(ST_STABLE);
    sb_check("stable_before_glitch", dbg_state);
    pll_lock = 1'b0;
    step();
    pll_lock = 1'b1;
    n = 8;
    expect_val(19);
    wait_cond(SEL_READY, 1'b1, n);
    sb_check("glitch_restarts_window", n);
    expect_val(0);
    sb_check("loss_count_stable_glitch", loss_count);

    // Reset in RUN with non-zero counts.
    pll_lock = 1'b0;
    apply_reset(2);
    n = 0;
    wait_cond(SEL_PLL_RESET, 1'b0, n);
    n = 0;
    wait_cond(SEL_PLL_RESET, 1'b1, n);
    pll_lock = 1'b1;
    n = 0;
    wait_cond(SEL_READY, 1'b1, n);
    pll_lock = 1'b0;
    step();
    pll_lock = 1'b1;
    n = 1;
    wait_cond(SEL_SYS_RST_N, 1'b0, n);
    n = 0;
    wait_cond(SEL_READY, 1'b1, n);
    expect_val({13'd0, 1'b0, 1'b1, 1'b1, 8'd1, 8'd1});
    sb_check("run_before_reset", pack_out());
    apply_reset(1);
    n = 0;
    expect_val(RST_PULSE);
    wait_cond(SEL_PLL_RESET, 1'b0, n);
    sb_check("pulse_after_run_reset", n);

    // Lock/timeout tie: lock_s reaches 1 exactly at cnt==LOCK_TIMEOUT-1.
    pll_lock = 1'b0;
    apply_reset(2);
    n = 0;
    wait_cond(SEL_PLL_RESET, 1'b0, n);
    repeat (LOCK_TIMEOUT - 3) step();
    pll_lock = 1'b1;
    repeat (3) step();
    expect_val(ST_STABLE);
    sb_check("tie_enters_stable", dbg_state);
    expect_val(0);
    sb_check("tie_timeout_count", timeout_count);
    expect_val(0);
    sb_check("tie_pll_reset", pll_reset);

    // One cycle later the timeout wins.
    pll_lock = 1'b0;
    apply_reset(2);
    n = 0;
    wait_cond(SEL_PLL_RESET, 1'b0, n);
    repeat (LOCK_TIMEOUT - 2) step();
    pll_lock = 1'b1;
    repeat (2) step();
    expect_val(ST_RESET_PLL);
    sb_check("late_lock_times_out", dbg_state);
    expect_val(1);
    sb_check("late_lock_timeout_count", timeout_count);

    // ---------------- report ----------------
    if (exp_q.size() != 0) $display("scoreboard: %0d expectations left over", exp_q.size());
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
